// File: rtl/sys_mem_arbiter_pkg.sv
// Shared types and defaults for the sys_mem arbiter: FSM encoding, port IDs and
// default bus widths and timing.
package sys_mem_arb_pkg;

   localparam int DEF_ADDR_W  = 6;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_RD_LAT  = 2;
   localparam int DEF_WR_HOLD = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      ACK   = 2'd3
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   function automatic port_e other_port(input port_e p);
      return (p == PORT_A) ? PORT_B : PORT_A;
   endfunction

endpackage

// File: rtl/sys_mem_arbiter_if.sv
// Bundles the two requester ports and the sys_mem side of the arbiter.
// Handshake: a requester raises x_req with its fields and keeps it high until
// x_ack pulses for one cycle; the fields are latched at grant, so they may change
// afterwards, and dropping x_req after the grant does not cancel the access.
interface sys_mem_arbiter_if #(
   parameter int ADDR_W = sys_mem_arb_pkg::DEF_ADDR_W,
   parameter int DATA_W = sys_mem_arb_pkg::DEF_DATA_W
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_adrs;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_adrs;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;

   logic              gnt_a;
   logic              gnt_b;
   logic              busy;

   logic [ADDR_W-1:0] mem_adrs;
   logic              mem_mode;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] mem_out;

   modport slave (
      input  a_req, a_we, a_adrs, a_wdata,
      input  b_req, b_we, b_adrs, b_wdata,
      input  mem_out,
      output a_ack, a_rdata, b_ack, b_rdata,
      output gnt_a, gnt_b, busy,
      output mem_adrs, mem_mode, mem_data
   );

   modport master (
      output a_req, a_we, a_adrs, a_wdata,
      output b_req, b_we, b_adrs, b_wdata,
      output mem_out,
      input  a_ack, a_rdata, b_ack, b_rdata,
      input  gnt_a, gnt_b, busy,
      input  mem_adrs, mem_mode, mem_data
   );

endinterface

// File: rtl/sys_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2
   import sys_mem_arb_pkg::*;
(
   input  logic  req_a,
   input  logic  req_b,
   input  port_e last_gnt,
   output port_e pick,
   output logic  valid
);

   always_comb begin
      valid = req_a | req_b;
      pick  = PORT_A;
      if (req_a && req_b) begin
         pick = other_port(last_gnt);
      end else if (req_b) begin
         pick = PORT_B;
      end
   end

endmodule

// File: rtl/sys_mem_arbiter.sv
// Shares the single sys_mem port between requesters A and B, sequencing the
// memory's multi-cycle read latency and write-hold window for the owner.
module sys_mem_arbiter
   import sys_mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RD_LAT  = DEF_RD_LAT,
   parameter int WR_HOLD = DEF_WR_HOLD
)(
   input  logic                clk,
   input  logic                rst_n,
   sys_mem_arbiter_if.slave    bus,
   output state_e              o_dbg_state
);

   localparam int CNT_MAX = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_HOLD - 1);

   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   port_e             r_last_gnt;
   logic              r_gnt_a;
   logic              r_gnt_b;
   logic              r_busy;
   logic              r_a_ack;
   logic              r_b_ack;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;
   logic [ADDR_W-1:0] r_mem_adrs;
   logic              r_mem_mode;
   logic [DATA_W-1:0] r_mem_data;

   port_e             w_pick;
   logic              w_valid;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_adrs;
   logic [DATA_W-1:0] w_sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req_a    (bus.a_req),
      .req_b    (bus.b_req),
      .last_gnt (r_last_gnt),
      .pick     (w_pick),
      .valid    (w_valid)
   );

   assign w_sel_we    = (w_pick == PORT_A) ? bus.a_we    : bus.b_we;
   assign w_sel_adrs  = (w_pick == PORT_A) ? bus.a_adrs  : bus.b_adrs;
   assign w_sel_wdata = (w_pick == PORT_A) ? bus.a_wdata : bus.b_wdata;

   // r_last_gnt doubles as the current owner while a transaction is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_last_gnt <= PORT_B;
         r_gnt_a    <= 1'b0;
         r_gnt_b    <= 1'b0;
         r_busy     <= 1'b0;
         r_a_ack    <= 1'b0;
         r_b_ack    <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
         r_mem_adrs <= '0;
         r_mem_mode <= 1'b0;
         r_mem_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_last_gnt <= w_pick;
                  r_gnt_a    <= (w_pick == PORT_A);
                  r_gnt_b    <= (w_pick == PORT_B);
                  r_busy     <= 1'b1;
                  r_cnt      <= '0;
                  r_mem_adrs <= w_sel_adrs;
                  r_mem_data <= w_sel_wdata;
                  r_mem_mode <= w_sel_we;
                  r_state    <= w_sel_we ? WRITE : READ;
               end
            end
            READ: begin
               if (r_cnt == RD_LAST) begin
                  r_cnt <= '0;
                  if (r_last_gnt == PORT_A) begin
                     r_a_rdata <= bus.mem_out;
                     r_a_ack   <= 1'b1;
                  end else begin
                     r_b_rdata <= bus.mem_out;
                     r_b_ack   <= 1'b1;
                  end
                  r_state <= ACK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WRITE: begin
               if (r_cnt == WR_LAST) begin
                  r_cnt      <= '0;
                  r_mem_mode <= 1'b0;
                  r_a_ack    <= (r_last_gnt == PORT_A);
                  r_b_ack    <= (r_last_gnt == PORT_B);
                  r_state    <= ACK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ACK: begin
               r_a_ack <= 1'b0;
               r_b_ack <= 1'b0;
               r_gnt_a <= 1'b0;
               r_gnt_b <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.a_ack    = r_a_ack;
   assign bus.b_ack    = r_b_ack;
   assign bus.a_rdata  = r_a_rdata;
   assign bus.b_rdata  = r_b_rdata;
   assign bus.gnt_a    = r_gnt_a;
   assign bus.gnt_b    = r_gnt_b;
   assign bus.busy     = r_busy;
   assign bus.mem_adrs = r_mem_adrs;
   assign bus.mem_mode = r_mem_mode;
   assign bus.mem_data = r_mem_data;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Bench for sys_mem_arbiter: directed scenarios followed by random A/B traffic,
// checked against a transaction-level model of arbitration order, latency and data.
module tb_sys_mem_arbiter;
  import sys_mem_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam int WH = 3;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  sys_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sys_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .WR_HOLD(WH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- sys_mem model (one registered read stage) ----------------
  logic [DW-1:0] tb_mem [64];

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 1) return 8'h5A;
    if (i == 5) return 8'h77;
    return 8'(i * 37 + 11);
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = init_val(i);
    bus.mem_out = '0;
    forever begin
      @(posedge clk);
      bus.mem_out <= tb_mem[bus.mem_adrs];
      if (bus.mem_mode) tb_mem[bus.mem_adrs] <= bus.mem_data;
    end
  end

  // ---------------- monitor ----------------
  int mode_cnt = 0;
  int a_ack_cnt = 0;
  int b_ack_cnt = 0;
  int mutex_err = 0;

  always @(negedge clk) begin
    if (bus.mem_mode) mode_cnt <= mode_cnt + 1;
    if (bus.a_ack) a_ack_cnt <= a_ack_cnt + 1;
    if (bus.b_ack) b_ack_cnt <= b_ack_cnt + 1;
    if (bus.gnt_a && bus.gnt_b) mutex_err <= mutex_err + 1;
  end

  // ---------------- scoreboard / reference model ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_q[$];
  port_e         ref_last;
  logic [DW-1:0] exp_a_rdata;
  logic [DW-1:0] exp_b_rdata;
  logic [AW-1:0] snap_adrs;
  logic [DW-1:0] snap_data;
  bit            snap_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int occupancy(input bit we);
    return we ? (WH + 2) : (RL + 2);
  endfunction

  task automatic model_txn(input port_e p, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    if (we) ref_mem[ad] = d;
    else if (p == PORT_A) exp_a_rdata = ref_mem[ad];
    else exp_b_rdata = ref_mem[ad];
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns ack cycle numbers (negedges
  // after launch, -1 on timeout) and monitor deltas over the run.
  task automatic run_pair(input bit ra, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                          input bit rb, input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                          output int ca, output int cb, output int d_mode, output int d_a, output int d_b);
    int m0, a0, b0;
    m0 = mode_cnt; a0 = a_ack_cnt; b0 = b_ack_cnt;
    ca = -1; cb = -1; snap_taken = 0;
    bus.a_req = ra; bus.a_we = wa; bus.a_adrs = aa; bus.a_wdata = da;
    bus.b_req = rb; bus.b_we = wb; bus.b_adrs = ab; bus.b_wdata = db;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!snap_taken && bus.busy) begin
        snap_adrs = bus.mem_adrs; snap_data = bus.mem_data; snap_taken = 1;
      end
      if (bus.a_ack && ca < 0) begin ca = k; bus.a_req = 1'b0; end
      if (bus.b_ack && cb < 0) begin cb = k; bus.b_req = 1'b0; end
      if ((!ra || ca >= 0) && (!rb || cb >= 0)) break;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clk);
    d_mode = mode_cnt - m0; d_a = a_ack_cnt - a0; d_b = b_ack_cnt - b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int ca, cb, dm, da, db, a0, n, mism;
    int ack_port [4];
    int ack_cyc [4];

    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    bus.a_req = 0; bus.a_we = 0; bus.a_adrs = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_adrs = '0; bus.b_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    ref_last = PORT_B; exp_a_rdata = '0; exp_b_rdata = '0;

    // reset values
    @(negedge clk);
    check("rst_a_ack", bus.a_ack, 0);
    check("rst_b_ack", bus.b_ack, 0);
    check("rst_gnt_a", bus.gnt_a, 0);
    check("rst_gnt_b", bus.gnt_b, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_mode", bus.mem_mode, 0);
    check("rst_mem_adrs", 32'(bus.mem_adrs), 0);
    check("rst_mem_data", 32'(bus.mem_data), 0);
    check("rst_a_rdata", 32'(bus.a_rdata), 0);
    check("rst_b_rdata", 32'(bus.b_rdata), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A reads address 1
    run_pair(1, 0, 6'd1, 8'h00, 0, 0, 6'd0, 8'h00, ca, cb, dm, da, db);
    model_txn(PORT_A, 0, 6'd1, 8'h00); ref_last = PORT_A;
    check("rdA_ack_cycle", ca, 3);
    check("rdA_rdata", 32'(bus.a_rdata), 32'h5A);
    check("rdA_mode_cycles", dm, 0);
    check("rdA_a_acks", da, 1);
    check("rdA_b_acks", db, 0);

    // B writes 0xC3 to address 3
    run_pair(0, 0, 6'd0, 8'h00, 1, 1, 6'd3, 8'hC3, ca, cb, dm, da, db);
    model_txn(PORT_B, 1, 6'd3, 8'hC3); ref_last = PORT_B;
    check("wrB_ack_cycle", cb, 4);
    check("wrB_mem_adrs", 32'(snap_adrs), 3);
    check("wrB_mem_data", 32'(snap_data), 32'hC3);
    check("wrB_mode_cycles", dm, 3);
    check("wrB_b_acks", db, 1);
    check("wrB_a_acks", da, 0);
    check("wrB_a_rdata", 32'(bus.a_rdata), 32'h5A);
    check("wrB_b_rdata", 32'(bus.b_rdata), 0);
    check("wrB_mem_cell", 32'(tb_mem[3]), 32'hC3);

    // both reads held from reset: A,B,A,B every 4 cycles
    rst_n = 1'b0;
    bus.a_req = 1; bus.a_we = 0; bus.a_adrs = 6'd1;
    bus.b_req = 1; bus.b_we = 0; bus.b_adrs = 6'd3;
    @(negedge clk);
    rst_n = 1'b1;
    ref_last = PORT_B;
    n = 0;
    for (int k = 1; k <= 24 && n < 4; k++) begin
      @(negedge clk);
      if (bus.a_ack && n < 4) begin ack_port[n] = 0; ack_cyc[n] = k; n++; end
      if (bus.b_ack && n < 4) begin ack_port[n] = 1; ack_cyc[n] = k; n++; end
    end
    bus.a_req = 0; bus.b_req = 0;
    @(negedge clk);
    check("rr_ack_count", n, 4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("rr_port_%0d", i), ack_port[i], i % 2);
      check($sformatf("rr_cycle_%0d", i), ack_cyc[i], 3 + 4 * i);
    end
    exp_a_rdata = ref_mem[1]; exp_b_rdata = ref_mem[3];
    check("rr_a_rdata", 32'(bus.a_rdata), 32'(exp_a_rdata));
    check("rr_b_rdata", 32'(bus.b_rdata), 32'(exp_b_rdata));
    check("rr_no_dual_grant", mutex_err, 0);

    // A held, B arrives during A's read: B is next
    bus.a_req = 1; bus.a_we = 0; bus.a_adrs = 6'd1;
    n = 0;
    for (int k = 1; k <= 24 && n < 2; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.b_req = 1; bus.b_we = 0; bus.b_adrs = 6'd3; end
      if (bus.a_ack && n < 2) begin ack_port[n] = 0; ack_cyc[n] = k; n++; end
      if (bus.b_ack && n < 2) begin ack_port[n] = 1; ack_cyc[n] = k; n++; end
    end
    bus.a_req = 0; bus.b_req = 0;
    @(negedge clk);
    check("late_b_ack_count", n, 2);
    check("late_b_first_port", ack_port[0], 0);
    check("late_b_first_cycle", ack_cyc[0], 3);
    check("late_b_second_port", ack_port[1], 1);
    check("late_b_second_cycle", ack_cyc[1], 7);
    ref_last = PORT_B;

    // A drops req right after grant; access still completes once
    a0 = a_ack_cnt; ca = -1;
    bus.a_req = 1; bus.a_we = 0; bus.a_adrs = 6'd5;
    @(negedge clk);
    bus.a_req = 0; bus.a_adrs = 6'd0;
    for (int k = 2; k <= 20 && ca < 0; k++) begin
      @(negedge clk);
      if (bus.a_ack) ca = k;
    end
    repeat (8) @(negedge clk);
    model_txn(PORT_A, 0, 6'd5, 8'h00); ref_last = PORT_A;
    check("drop_ack_cycle", ca, 3);
    check("drop_rdata", 32'(bus.a_rdata), 32'h77);
    check("drop_single_ack", a_ack_cnt - a0, 1);
    check("drop_idle_after", bus.busy, 0);

    // reset in the 2nd cycle of a write
    bus.a_req = 1; bus.a_we = 1; bus.a_adrs = 6'd9; bus.a_wdata = 8'hE1;
    a0 = a_ack_cnt;
    @(negedge clk);
    @(negedge clk);
    check("abort_mode_before", bus.mem_mode, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mode", bus.mem_mode, 0);
    check("abort_gnt_a", bus.gnt_a, 0);
    check("abort_gnt_b", bus.gnt_b, 0);
    check("abort_busy", bus.busy, 0);
    bus.a_req = 0;
    repeat (2) @(negedge clk);
    check("abort_no_ack", a_ack_cnt - a0, 0);
    ref_mem[9] = tb_mem[9];
    rst_n = 1'b1;
    ref_last = PORT_B; exp_a_rdata = '0; exp_b_rdata = '0;
    run_pair(1, 0, 6'd5, 8'h00, 1, 0, 6'd1, 8'h00, ca, cb, dm, da, db);
    model_txn(PORT_A, 0, 6'd5, 8'h00); model_txn(PORT_B, 0, 6'd1, 8'h00); ref_last = PORT_B;
    check("post_rst_a_first", ca, 3);
    check("post_rst_b_second", cb, 7);
    check("post_rst_a_rdata", 32'(bus.a_rdata), 32'(exp_a_rdata));
    check("post_rst_b_rdata", 32'(bus.b_rdata), 32'(exp_b_rdata));

    // random traffic
    for (int it = 0; it < 40; it++) begin
      bit ra, rb, wa, wb;
      logic [AW-1:0] aa, ab;
      logic [DW-1:0] dda, ddb;
      int exp_ca, exp_cb;
      port_e w;
      ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      aa = AW'($urandom_range(0, 63)); ab = AW'($urandom_range(0, 63));
      dda = DW'($urandom); ddb = DW'($urandom);
      exp_ca = -1; exp_cb = -1;
      if (ra && rb) begin
        w = other_port(ref_last);
        if (w == PORT_A) begin
          exp_ca = occupancy(wa) - 1;
          exp_cb = occupancy(wa) + occupancy(wb) - 1;
          model_txn(PORT_A, wa, aa, dda); model_txn(PORT_B, wb, ab, ddb);
          ref_last = PORT_B;
        end else begin
          exp_cb = occupancy(wb) - 1;
          exp_ca = occupancy(wb) + occupancy(wa) - 1;
          model_txn(PORT_B, wb, ab, ddb); model_txn(PORT_A, wa, aa, dda);
          ref_last = PORT_A;
        end
      end else if (ra) begin
        exp_ca = occupancy(wa) - 1;
        model_txn(PORT_A, wa, aa, dda); ref_last = PORT_A;
      end else begin
        exp_cb = occupancy(wb) - 1;
        model_txn(PORT_B, wb, ab, ddb); ref_last = PORT_B;
      end
      exp_q.push_back(exp_a_rdata);
      exp_q.push_back(exp_b_rdata);
      run_pair(ra, wa, aa, dda, rb, wb, ab, ddb, ca, cb, dm, da, db);
      check($sformatf("rnd%0d_a_cycle", it), ca, exp_ca);
      check($sformatf("rnd%0d_b_cycle", it), cb, exp_cb);
      check($sformatf("rnd%0d_a_acks", it), da, 32'(ra));
      check($sformatf("rnd%0d_b_acks", it), db, 32'(rb));
      check($sformatf("rnd%0d_mode_cycles", it), dm, WH * ((ra && wa) ? 1 : 0) + WH * ((rb && wb) ? 1 : 0));
      check($sformatf("rnd%0d_a_rdata", it), 32'(bus.a_rdata), 32'(exp_q.pop_front()));
      check($sformatf("rnd%0d_b_rdata", it), 32'(bus.b_rdata), 32'(exp_q.pop_front()));
    end

    mism = 0;
    for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
    check("final_mem_contents", mism, 0);
    check("final_no_dual_grant", mutex_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
